datacache_sa: RTL and testbench
===============================

// Module: datacache_sa
// PURPOSE
//  Parametrised, set-associative, write-back, write-allocate data cache between the CPU data port and block-wide data memory.
//  Successor to the direct-mapped data cache. Adds: configurable ways/sets/block size, true-LRU replacement,
//  valid/ready handshakes on both sides, synchronous reset, and a clocked flush FSM with completion signalling.
// PARAMETERS
//  WORD_SIZE   32  data word width (bits); accesses are whole, word-aligned words
//  ADDR_WIDTH  32  byte address width
//  WAYS        2   associativity (1 or 2; LRU is one bit per set)
//  SETS        8   number of sets (power of 2)
//  BLOCK_WORDS 4   words per line (power of 2); line = BLOCK_WORDS*WORD_SIZE bits
// PORTS
//  clk         in   1        clock; all state updates on posedge
//  rst_n       in   1        synchronous active-low reset
//  req_valid   in   1        CPU request valid
//  req_ready   out  1        cache can accept a request (state IDLE)
//  req_we      in   1        1 = write, 0 = read
//  req_addr    in   ADDR_WIDTH  byte address; bits [1:0] ignored
//  req_wdata   in   WORD_SIZE   write data
//  resp_valid  out  1        one-cycle pulse: request complete (reads and writes)
//  resp_rdata  out  WORD_SIZE   read data; held until next resp_valid
//  hit         out  1        with resp_valid: 1 = access hit without refill
//  flush       in   1        level; sampled in IDLE; starts write-back of all dirty lines
//  flush_done  out  1        one-cycle pulse when flush completes
//  mem_req     out  1        memory request; held until mem_ack
//  mem_we      out  1        1 = line write-back, 0 = line fill
//  mem_addr    out  ADDR_WIDTH  line-aligned byte address
//  mem_wdata   out  BLOCK_WORDS*WORD_SIZE  victim line (word 0 in LSBs)
//  mem_rdata   in   BLOCK_WORDS*WORD_SIZE  fill line, valid with mem_ack
//  mem_ack     in   1        one-cycle completion of the current mem_req
// BEHAVIOUR
//  Address split: word offset = addr[log2(BLOCK_WORDS)+1:2]; index = next log2(SETS) bits; tag = remaining upper bits.
//  Reset (rst_n=0 at posedge): all Valid, Dirty and LRU bits = 0; state IDLE.
//    Outputs after reset: req_ready=1; resp_valid=0; resp_rdata=0; hit=0; flush_done=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0.
//    Reset mid-miss or mid-flush aborts; a pending mem_ack after reset is ignored.
//  FSM states:
//    IDLE: req_ready=1.
//      flush=1 has priority over req_valid: go to FLUSH with scan pointer (set 0, way 0).
//      Otherwise req_valid=1 latches the request and goes to LOOKUP.
//    LOOKUP:
//      Hit: read returns the word; write merges the word into the line and sets Dirty.
//        Hit way becomes MRU. resp_valid=1 and hit=1 in the next cycle. Return to IDLE.
//        Hit latency: 2 cycles from acceptance to resp_valid.
//      Miss: victim = first invalid way (lowest index), else the LRU way.
//        Victim valid and dirty -> WB; otherwise -> FILL.
//    WB: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line.
//      On mem_ack: clear Dirty and go to FILL.
//    FILL: mem_req=1, mem_we=0, mem_addr=line address of the request.
//      On mem_ack: install the line; set Valid and tag.
//        Write request: merge the word and set Dirty=1. Read request: Dirty=0.
//      Make the way MRU. Next cycle: resp_valid=1, hit=0. Return to IDLE.
//    FLUSH: visit (set, way) in order, one per cycle, skipping lines that are clean or invalid.
//      Dirty line: mem_req write-back, then wait for mem_ack and clear Dirty.
//      After the last entry: flush_done=1 for one cycle, then IDLE.
//      Lines remain Valid; tags and LRU are unchanged.
//  mem_req, mem_we, mem_addr and mem_wdata are stable while mem_req=1. mem_ack while mem_req=0 is ignored.
//  req_* inputs are only sampled when req_valid && req_ready.
//  WAYS=1 degenerates to direct-mapped; LRU is then unused.
// TESTING
//  1. Reset, read 0x0000_0040 -> mem_req fill @0x40 (mem_we=0); ack line {D,C,B,A} -> resp_rdata=A, hit=0.
//     Read 0x44 -> resp_rdata=B, hit=1, 2 cycles after acceptance.
//  2. Write 0x40 = 0xDEADBEEF (hit), then read 0x40 -> 0xDEADBEEF, hit=1; no mem_req is issued.
//  3. With SETS=8, BLOCK_WORDS=4: dirty 0x40, fill 0x240 (same set, second way), touch 0x240, then read 0x440.
//     -> write-back @0x40 carrying 0xDEADBEEF first, then fill @0x440. Line 0x240 is retained.
//  4. Dirty lines in sets 1 and 5, assert flush -> exactly 2 write-backs, in set order.
//     -> one flush_done pulse. A following read of the set-1 address hits.
//  5. flush and req_valid both asserted in IDLE -> flush is served first; req_ready=0 until flush_done.
//  6. rst_n=0 while mem_req=1 in WB -> next cycle mem_req=0, req_ready=1.
//     A previously cached address now misses.

Source files
------------

// File: rtl/datacache_sa_if.sv
// Bundle of the CPU-side and memory-side handshake signals of datacache_sa.
//   slave  : the cache's view (takes CPU requests, drives memory requests)
//   master : the environment's view (CPU plus line-wide memory)
interface datacache_sa_if #(
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
);
  localparam int LINE_W = BLOCK_WORDS * WORD_SIZE;

  // CPU side
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WORD_SIZE-1:0]  req_wdata;
  logic                  resp_valid;
  logic [WORD_SIZE-1:0]  resp_rdata;
  logic                  hit;
  logic                  flush;
  logic                  flush_done;
  // memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, flush, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, hit, flush_done,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, flush, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, hit, flush_done,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/datacache_sa.sv
// datacache_sa: set-associative (1 or 2 ways), write-back, write-allocate data
// cache with true-LRU replacement and a clocked flush engine.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : datacache_sa_if.slave
//     req_valid/req_ready/req_we/req_addr/req_wdata : CPU request
//     resp_valid/resp_rdata/hit                      : CPU response (1-cycle pulse)
//     flush/flush_done                               : write back all dirty lines
//     mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : line-wide memory port
// SETS and BLOCK_WORDS must be powers of two and at least 2.

// Tag compare for one way of the addressed set.
module datacache_sa_way #(
  parameter int TAG_W = 25
) (
  input  logic             valid,
  input  logic [TAG_W-1:0] tag_stored,
  input  logic [TAG_W-1:0] tag_req,
  output logic             hit
);
  assign hit = valid && (tag_stored == tag_req);
endmodule

module datacache_sa #(
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAYS        = 2,
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  datacache_sa_if.slave bus
);
  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W - 2;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = BLOCK_WORDS * WORD_SIZE;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_FILL, S_FSCAN, S_FWB
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [TAG_W-1:0]     tag;
    logic [IDX_W-1:0]     idx;
    logic [OFF_W-1:0]     off;
    logic [WORD_SIZE-1:0] wdata;
  } req_t;

  state_t                    state;
  req_t                      rq;
  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  logic [SETS-1:0]           lru_q;          // index of the LRU way
  logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
  logic [LINE_W-1:0]         data_q [SETS][WAYS];
  logic [WAY_W-1:0]          vic_q;
  logic [IDX_W-1:0]          fset_q;
  logic [WAY_W-1:0]          fway_q;

  // Byte offset bits are never used: accesses are whole aligned words.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.req_addr[1:0];

  function automatic logic [WORD_SIZE-1:0] get_word(logic [LINE_W-1:0] line,
                                                    logic [OFF_W-1:0]  off);
    return line[int'(off)*WORD_SIZE +: WORD_SIZE];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(logic [LINE_W-1:0]    line,
                                                 logic [OFF_W-1:0]     off,
                                                 logic [WORD_SIZE-1:0] w);
    logic [LINE_W-1:0] l;
    l = line;
    l[int'(off)*WORD_SIZE +: WORD_SIZE] = w;
    return l;
  endfunction

  // Per-way tag compare against the latched request
  logic [WAYS-1:0] way_hit;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    datacache_sa_way #(.TAG_W(TAG_W)) u_way (
      .valid      (valid_q[rq.idx][w]),
      .tag_stored (tag_q[rq.idx][w]),
      .tag_req    (rq.tag),
      .hit        (way_hit[w])
    );
  end

  logic             hit_any;
  logic [WAY_W-1:0] hit_way, vic_way;
  logic             flush_last;
  logic [ADDR_WIDTH-1:0] req_line;

  always_comb begin
    hit_any = |way_hit;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_way = WAY_W'(w);
    // Lowest-index invalid way wins; otherwise evict the LRU way.
    vic_way = (WAYS > 1) ? WAY_W'(lru_q[rq.idx]) : '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[rq.idx][w]) vic_way = WAY_W'(w);
  end

  assign req_line   = {rq.tag, rq.idx, {(OFF_W + 2){1'b0}}};
  assign flush_last = (fset_q == IDX_W'(SETS - 1)) && (fway_q == WAY_W'(WAYS - 1));
  assign bus.req_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      rq             <= '0;
      valid_q        <= '0;
      dirty_q        <= '0;
      lru_q          <= '0;
      vic_q          <= '0;
      fset_q         <= '0;
      fway_q         <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.hit        <= 1'b0;
      bus.flush_done <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.flush_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.flush) begin
            fset_q <= '0;
            fway_q <= '0;
            state  <= S_FSCAN;
          end else if (bus.req_valid) begin
            rq <= '{we:    bus.req_we,
                    tag:   bus.req_addr[ADDR_WIDTH-1 -: TAG_W],
                    idx:   bus.req_addr[OFF_W+2 +: IDX_W],
                    off:   bus.req_addr[2 +: OFF_W],
                    wdata: bus.req_wdata};
            state <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (hit_any) begin
            if (rq.we) begin
              data_q[rq.idx][hit_way]  <= put_word(data_q[rq.idx][hit_way], rq.off, rq.wdata);
              dirty_q[rq.idx][hit_way] <= 1'b1;
            end else begin
              bus.resp_rdata <= get_word(data_q[rq.idx][hit_way], rq.off);
            end
            lru_q[rq.idx]  <= (WAYS > 1) ? ~hit_way[0] : 1'b0;
            bus.resp_valid <= 1'b1;
            bus.hit        <= 1'b1;
            state          <= S_IDLE;
          end else begin
            vic_q       <= vic_way;
            bus.mem_req <= 1'b1;
            if (valid_q[rq.idx][vic_way] && dirty_q[rq.idx][vic_way]) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {tag_q[rq.idx][vic_way], rq.idx, {(OFF_W + 2){1'b0}}};
              bus.mem_wdata <= data_q[rq.idx][vic_way];
              state         <= S_WB;
            end else begin
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= req_line;
              state        <= S_FILL;
            end
          end
        end

        S_WB: begin
          // mem_req stays high; the fill request follows directly.
          if (bus.mem_ack) begin
            dirty_q[rq.idx][vic_q] <= 1'b0;
            bus.mem_we             <= 1'b0;
            bus.mem_addr           <= req_line;
            state                  <= S_FILL;
          end
        end

        S_FILL: begin
          if (bus.mem_ack) begin
            data_q[rq.idx][vic_q]  <= rq.we ? put_word(bus.mem_rdata, rq.off, rq.wdata)
                                            : bus.mem_rdata;
            tag_q[rq.idx][vic_q]   <= rq.tag;
            valid_q[rq.idx][vic_q] <= 1'b1;
            dirty_q[rq.idx][vic_q] <= rq.we;
            lru_q[rq.idx]          <= (WAYS > 1) ? ~vic_q[0] : 1'b0;
            if (!rq.we) bus.resp_rdata <= get_word(bus.mem_rdata, rq.off);
            bus.resp_valid <= 1'b1;
            bus.hit        <= 1'b0;
            bus.mem_req    <= 1'b0;
            state          <= S_IDLE;
          end
        end

        S_FSCAN: begin
          if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= {tag_q[fset_q][fway_q], fset_q, {(OFF_W + 2){1'b0}}};
            bus.mem_wdata <= data_q[fset_q][fway_q];
            state         <= S_FWB;
          end else if (flush_last) begin
            bus.flush_done <= 1'b1;
            state          <= S_IDLE;
          end else if (fway_q == WAY_W'(WAYS - 1)) begin
            fway_q <= '0;
            fset_q <= fset_q + 1'b1;
          end else begin
            fway_q <= fway_q + 1'b1;
          end
        end

        S_FWB: begin
          if (bus.mem_ack) begin
            dirty_q[fset_q][fway_q] <= 1'b0;
            bus.mem_req             <= 1'b0;
            bus.mem_we              <= 1'b0;
            if (flush_last) begin
              bus.flush_done <= 1'b1;
              state          <= S_IDLE;
            end else begin
              if (fway_q == WAY_W'(WAYS - 1)) begin
                fway_q <= '0;
                fset_q <= fset_q + 1'b1;
              end else begin
                fway_q <= fway_q + 1'b1;
              end
              state <= S_FSCAN;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_datacache_sa.sv
module tb_datacache_sa;
  localparam logic [31:0] WA = 32'hAAAA_0000, WB_ = 32'hBBBB_0001,
                          WC = 32'hCCCC_0002, WD = 32'hDDDD_0003;
  localparam logic [31:0] PAT = 32'h1000_0000;  // fresh memory word = byte addr + PAT

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datacache_sa_if #(.WORD_SIZE(32), .ADDR_WIDTH(32), .BLOCK_WORDS(4)) mif ();

  datacache_sa #(.WORD_SIZE(32), .ADDR_WIDTH(32), .WAYS(2), .SETS(8), .BLOCK_WORDS(4))
    dut (.clk(clk), .rst_n(rst_n), .bus(mif));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- memory model / responder ----
  typedef struct {logic we; logic [31:0] addr; logic [127:0] wdata;} mop_t;
  mop_t mlog[$];
  logic [127:0] memory [logic [31:0]];
  bit mem_en = 1'b1;

  function automatic logic [127:0] fresh_line(logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = a + 32'(4 * i) + PAT;
    return l;
  endfunction

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mif.mem_ack) begin
        mif.mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_en && mif.mem_req) begin
        cnt++;
        if (cnt >= 2) begin
          mlog.push_back('{mif.mem_we, mif.mem_addr, mif.mem_wdata});
          if (mif.mem_we) memory[mif.mem_addr] = mif.mem_wdata;
          else mif.mem_rdata = memory.exists(mif.mem_addr) ? memory[mif.mem_addr]
                                                           : fresh_line(mif.mem_addr);
          mif.mem_ack = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---- CPU request driver ----
  task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic h, output int lat);
    int n;
    @(negedge clk);
    mif.req_valid = 1'b1; mif.req_we = we; mif.req_addr = a; mif.req_wdata = wd;
    n = 0;
    while (!mif.req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    mif.req_valid = 1'b0;
    lat = 1;
    while (!mif.resp_valid && lat < 300) begin @(negedge clk); lat++; end
    rd = mif.resp_rdata;
    h  = mif.hit;
    if (!mif.resp_valid) lat = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata;
    logic exp_hit; logic [31:0] exp_rdata;
    int exp_nmem; logic [31:0] exp_a0; logic exp_we0; logic [31:0] exp_wd0; logic [31:0] exp_a1;
  } vec_t;
  vec_t vecs[12];

  initial begin
    logic [31:0] rd;
    logic h;
    int lat, ndone, rdy_bad, n;

    mif.req_valid = 0; mif.req_we = 0; mif.req_addr = 0; mif.req_wdata = 0;
    mif.flush = 0; mif.mem_ack = 0; mif.mem_rdata = '0;
    memory[32'h40] = {WD, WC, WB_, WA};

    //          we addr        wdata         hit rdata              nmem a0          we0 wd0           a1
    vecs[0]  = '{0, 32'h40,  32'h0,        0, WA,                 1, 32'h40,  0, 32'h0,        32'h0};
    vecs[1]  = '{0, 32'h44,  32'h0,        1, WB_,                0, 32'h0,   0, 32'h0,        32'h0};
    vecs[2]  = '{1, 32'h40,  32'hDEADBEEF, 1, 32'h0,              0, 32'h0,   0, 32'h0,        32'h0};
    vecs[3]  = '{0, 32'h40,  32'h0,        1, 32'hDEADBEEF,       0, 32'h0,   0, 32'h0,        32'h0};
    vecs[4]  = '{0, 32'h4C,  32'h0,        1, WD,                 0, 32'h0,   0, 32'h0,        32'h0};
    vecs[5]  = '{0, 32'h80,  32'h0,        0, 32'h80 + PAT,       1, 32'h80,  0, 32'h0,        32'h0};
    vecs[6]  = '{1, 32'h84,  32'h12345678, 1, 32'h0,              0, 32'h0,   0, 32'h0,        32'h0};
    vecs[7]  = '{0, 32'h84,  32'h0,        1, 32'h12345678,       0, 32'h0,   0, 32'h0,        32'h0};
    vecs[8]  = '{0, 32'h240, 32'h0,        0, 32'h240 + PAT,      1, 32'h240, 0, 32'h0,        32'h0};
    vecs[9]  = '{0, 32'h244, 32'h0,        1, 32'h244 + PAT,      0, 32'h0,   0, 32'h0,        32'h0};
    vecs[10] = '{0, 32'h440, 32'h0,        0, 32'h440 + PAT,      2, 32'h40,  1, 32'hDEADBEEF, 32'h440};
    vecs[11] = '{0, 32'h248, 32'h0,        1, 32'h248 + PAT,      0, 32'h0,   0, 32'h0,        32'h0};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst req_ready",  32'(mif.req_ready),  32'd1);
    check("rst resp_valid", 32'(mif.resp_valid), 32'd0);
    check("rst resp_rdata", mif.resp_rdata,      32'd0);
    check("rst hit",        32'(mif.hit),        32'd0);
    check("rst flush_done", 32'(mif.flush_done), 32'd0);
    check("rst mem_req",    32'(mif.mem_req),    32'd0);
    check("rst mem_we",     32'(mif.mem_we),     32'd0);
    check("rst mem_addr",   mif.mem_addr,        32'd0);
    check("rst mem_wdata",  32'(|mif.mem_wdata), 32'd0);

    // ---- table: fill, hits, write hit, eviction with write-back ----
    for (int i = 0; i < 12; i++) begin
      mlog.delete();
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, h, lat);
      check($sformatf("v%0d resp", i), 32'(lat > 0), 32'd1);
      check($sformatf("v%0d hit", i), 32'(h), 32'(vecs[i].exp_hit));
      if (!vecs[i].we) check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      if (vecs[i].exp_hit) check($sformatf("v%0d latency", i), 32'(lat), 32'd2);
      check($sformatf("v%0d nmem", i), 32'(mlog.size()), 32'(vecs[i].exp_nmem));
      if (vecs[i].exp_nmem >= 1 && mlog.size() >= 1) begin
        check($sformatf("v%0d mem_addr0", i), mlog[0].addr, vecs[i].exp_a0);
        check($sformatf("v%0d mem_we0", i), 32'(mlog[0].we), 32'(vecs[i].exp_we0));
        if (vecs[i].exp_we0) check($sformatf("v%0d mem_wdata0", i), mlog[0].wdata[31:0], vecs[i].exp_wd0);
      end
      if (vecs[i].exp_nmem >= 2 && mlog.size() >= 2) begin
        check($sformatf("v%0d mem_addr1", i), mlog[1].addr, vecs[i].exp_a1);
        check($sformatf("v%0d mem_we1", i), 32'(mlog[1].we), 32'd0);
      end
    end

    // ---- flush with concurrent request: sets 1 and 5 dirty ----
    do_reset();
    run_req(1'b1, 32'h10, 32'h1111_0000, rd, h, lat);
    run_req(1'b1, 32'h54, 32'h5555_0000, rd, h, lat);
    mlog.delete();
    @(negedge clk);
    mif.flush = 1'b1;
    mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_addr = 32'h10; mif.req_wdata = '0;
    ndone = 0; rdy_bad = 0; n = 0;
    @(negedge clk);
    while (n < 300) begin
      if (mif.flush_done) begin ndone++; mif.flush = 1'b0; break; end
      if (mif.req_ready) rdy_bad++;
      @(negedge clk);
      n++;
    end
    check("flush done seen", 32'(ndone), 32'd1);
    check("flush req_ready low", 32'(rdy_bad), 32'd0);
    check("flush nmem", 32'(mlog.size()), 32'd2);
    if (mlog.size() == 2) begin
      check("flush wb0 addr",  mlog[0].addr, 32'h10);
      check("flush wb0 we",    32'(mlog[0].we), 32'd1);
      check("flush wb0 data",  mlog[0].wdata[31:0], 32'h1111_0000);
      check("flush wb1 addr",  mlog[1].addr, 32'h50);
      check("flush wb1 data",  mlog[1].wdata[63:32], 32'h5555_0000);
    end
    // pending request is accepted at the next edge; should hit
    @(posedge clk);
    @(negedge clk);
    mif.req_valid = 1'b0;
    lat = 1;
    while (!mif.resp_valid && lat < 300) begin
      if (mif.flush_done) ndone++;
      @(negedge clk); lat++;
    end
    check("post-flush resp latency", 32'(lat), 32'd2);
    check("post-flush hit", 32'(mif.hit), 32'd1);
    check("post-flush rdata", mif.resp_rdata, 32'h1111_0000);
    check("flush_done pulses", 32'(ndone), 32'd1);
    check("post-flush nmem", 32'(mlog.size()), 32'd2);

    // ---- reset during write-back ----
    run_req(1'b1, 32'h10, 32'h2222_0000, rd, h, lat);
    check("rw hit", 32'(h), 32'd1);
    run_req(1'b0, 32'h110, 32'h0, rd, h, lat);
    check("rw fill 0x110", rd, 32'h110 + PAT);
    mem_en = 1'b0;
    @(negedge clk);
    mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_addr = 32'h210;
    @(negedge clk);
    mif.req_valid = 1'b0;
    n = 0;
    while (!(mif.mem_req && mif.mem_we) && n < 50) begin @(negedge clk); n++; end
    check("wb issued", 32'(mif.mem_req && mif.mem_we), 32'd1);
    check("wb addr", mif.mem_addr, 32'h10);
    check("wb data", mif.mem_wdata[31:0], 32'h2222_0000);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst mid-wb mem_req", 32'(mif.mem_req), 32'd0);
    check("rst mid-wb req_ready", 32'(mif.req_ready), 32'd1);
    rst_n = 1'b1;
    mif.mem_ack = 1'b1;                 // stale ack must be ignored
    @(negedge clk);
    mif.mem_ack = 1'b0;
    check("stale ack resp_valid", 32'(mif.resp_valid), 32'd0);
    check("stale ack mem_req", 32'(mif.mem_req), 32'd0);
    check("stale ack req_ready", 32'(mif.req_ready), 32'd1);
    mem_en = 1'b1;
    mlog.delete();
    run_req(1'b0, 32'h110, 32'h0, rd, h, lat);
    check("after rst resp", 32'(lat > 0), 32'd1);
    check("after rst miss", 32'(h), 32'd0);
    check("after rst rdata", rd, 32'h110 + PAT);
    check("after rst nmem", 32'(mlog.size()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
